// File: rtl/blkdev_pkg.sv
// Shared types and constants for the block-device controller.
package blkdev_pkg;

   // Transfer FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      FIN  = 2'd3
   } state_e;

   // CSR bit positions
   localparam int CSR_DONE     = 31;
   localparam int CSR_START_RD = 30;
   localparam int CSR_START_WR = 29;
   localparam int CSR_ERR      = 28;
   localparam int CSR_IE       = 27;
   localparam int CSR_BUSY     = 26;
   localparam int CSR_ABORT    = 25;

   // Bus size encodings on sel_i
   localparam logic [1:0] SEL_BYTE = 2'd0;
   localparam logic [1:0] SEL_HALF = 2'd1;

   // Byte-lane enables for a bus write of the given size at the given offset
   function automatic logic [3:0] lane_be(input logic [1:0] sel, input logic [1:0] off);
      case (sel)
         SEL_BYTE: return 4'b0001 << off;
         SEL_HALF: return off[1] ? 4'b1100 : 4'b0011;
         default:  return 4'b1111;
      endcase
   endfunction

   // Replicate the narrow write data across all lanes so any enabled lane picks it up
   function automatic logic [31:0] lane_wdata(input logic [1:0] sel, input logic [31:0] d);
      case (sel)
         SEL_BYTE: return {4{d[7:0]}};
         SEL_HALF: return {2{d[15:0]}};
         default:  return d;
      endcase
   endfunction

endpackage

// File: rtl/blkdev_ctrl_if.sv
// Processor-side bus of the block-device controller.
interface blkdev_ctrl_if;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic [1:0]  sel_i;
   logic        rd_i;
   logic        we_i;
   logic        ack_o;

   modport master (output addr_i, data_i, sel_i, rd_i, we_i, input data_o, ack_o);
   modport slave  (input addr_i, data_i, sel_i, rd_i, we_i, output data_o, ack_o);
endinterface

// File: rtl/blkdev_buffer.sv
// Single-port block buffer: asynchronous read, synchronous byte-enabled write.
module blkdev_buffer #(
   parameter int   WORDS = 128,
   localparam int  IDX_W = $clog2(WORDS)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [3:0]       be,
   input  logic [IDX_W-1:0] addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [3:0][7:0] mem [WORDS];

   // Write only the enabled byte lanes of the addressed word
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[addr][b] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/blkdev_ctrl.sv
// Block-device controller: CSR/BAR registers, a one-block buffer, and an FSM
// that streams the buffer to/from the backend one word per ack.
module blkdev_ctrl
   import blkdev_pkg::*;
#(
   parameter logic [31:0] CTRL_ADDR = 32'hFFFF_FE00,
   parameter int          WORDS     = 128,
   parameter int          BADDR_W   = 26,
   parameter int          TIMEOUT   = 65535
) (
   input  logic               clk,
   input  logic               rst,
   blkdev_ctrl_if.slave       bus,
   output logic               interrupt,
   output logic [BADDR_W-1:0] blk_addr_o,
   output logic [31:0]        blk_wdata_o,
   input  logic [31:0]        blk_rdata_i,
   output logic               blk_rd_o,
   output logic               blk_we_o,
   input  logic               blk_ack_i
);

   localparam int               IDX_W    = $clog2(WORDS);
   localparam int               TMO_W    = $clog2(TIMEOUT + 1);
   localparam logic [31:0]      BAR_ADDR = CTRL_ADDR + 32'd4;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               ie_q, ie_d;
   logic [BADDR_W-1:0] bar_q, bar_d;

   logic             is_csr, is_bar, busy, idle, csr_wr;
   logic [IDX_W-1:0] bus_idx;
   logic             buf_we;
   logic [3:0]       buf_be;
   logic [IDX_W-1:0] buf_addr;
   logic [31:0]      buf_wdata, buf_rdata;
   logic [31:0]      csr_rd, bus_rd_ext;

   assign is_csr  = (bus.addr_i == CTRL_ADDR);
   assign is_bar  = (bus.addr_i == BAR_ADDR);
   assign busy    = (state_q == RD) || (state_q == WR);
   assign idle    = (state_q == IDLE);
   assign csr_wr  = bus.we_i && is_csr;
   assign bus_idx = bus.addr_i[IDX_W+1:2];

   // Register access always completes at once; buffer access stalls until the FSM is idle
   assign bus.ack_o = (bus.rd_i || bus.we_i) && (is_csr || is_bar || idle);

   assign interrupt   = done_q && ie_q;
   assign blk_rd_o    = (state_q == RD);
   assign blk_we_o    = (state_q == WR);
   assign blk_addr_o  = busy ? bar_q : '0;
   assign blk_wdata_o = (state_q == WR) ? buf_rdata : 32'd0;

   // Buffer port belongs to the bus while idle and to the word counter during a transfer
   always_comb begin
      buf_addr  = bus_idx;
      buf_we    = idle && bus.we_i && !is_csr && !is_bar;
      buf_be    = lane_be(bus.sel_i, bus.addr_i[1:0]);
      buf_wdata = lane_wdata(bus.sel_i, bus.data_i);
      if (busy) begin
         buf_addr  = cnt_q;
         buf_we    = (state_q == RD) && blk_ack_i;
         buf_be    = 4'b1111;
         buf_wdata = blk_rdata_i;
      end
   end

   blkdev_buffer #(.WORDS(WORDS)) u_buf (
      .clk   (clk),
      .we    (buf_we),
      .be    (buf_be),
      .addr  (buf_addr),
      .wdata (buf_wdata),
      .rdata (buf_rdata)
   );

   // Read data: register images, or the addressed lane of the buffer zero-extended
   always_comb begin
      csr_rd           = '0;
      csr_rd[CSR_DONE] = done_q;
      csr_rd[CSR_ERR]  = err_q;
      csr_rd[CSR_IE]   = ie_q;
      csr_rd[CSR_BUSY] = busy;
      case (bus.sel_i)
         SEL_BYTE: bus_rd_ext = 32'(8'(buf_rdata >> {bus.addr_i[1:0], 3'b000}));
         SEL_HALF: bus_rd_ext = 32'(16'(buf_rdata >> {bus.addr_i[1], 4'b0000}));
         default:  bus_rd_ext = buf_rdata;
      endcase
      bus.data_o = 32'd0;
      if (bus.rd_i) begin
         if (is_csr)      bus.data_o = csr_rd;
         else if (is_bar) bus.data_o = 32'(bar_q);
         else if (idle)   bus.data_o = bus_rd_ext;
      end
   end

   // Next-state: software register writes first, then FSM events so hardware sets win
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      done_d  = done_q;
      err_d   = err_q;
      ie_d    = ie_q;
      bar_d   = bar_q;

      if (csr_wr) begin
         ie_d = bus.data_i[CSR_IE];
         if (bus.data_i[CSR_DONE]) done_d = 1'b0;
         if (bus.data_i[CSR_ERR])  err_d  = 1'b0;
      end
      if (bus.we_i && is_bar && !busy) bar_d = bus.data_i[BADDR_W-1:0];

      case (state_q)
         IDLE: begin
            if (csr_wr && (bus.data_i[CSR_START_RD] || bus.data_i[CSR_START_WR])) begin
               state_d = bus.data_i[CSR_START_RD] ? RD : WR;
               cnt_d   = '0;
               tmo_d   = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         RD, WR: begin
            if (blk_ack_i) begin
               cnt_d = cnt_q + 1'b1;
               tmo_d = '0;
               if (cnt_q == LAST_IDX) state_d = FIN;
            end else begin
               tmo_d = tmo_q + 1'b1;
               if (tmo_q == TMO_LAST) begin
                  state_d = FIN;
                  err_d   = 1'b1;
               end
            end
            if (csr_wr && bus.data_i[CSR_ABORT]) begin
               state_d = FIN;
               err_d   = 1'b1;
            end
         end
         FIN: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and register flops; buffer contents are not reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tmo_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ie_q    <= 1'b0;
         bar_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ie_q    <= ie_d;
         bar_q   <= bar_d;
      end
   end

endmodule

// File: tb/tb_blkdev_ctrl.sv
// Directed + randomized bench for blkdev_ctrl with a word-array reference model.
module tb_blkdev_ctrl;

   localparam logic [31:0] CSR_A = 32'hFFFF_FE00;
   localparam logic [31:0] BAR_A = 32'hFFFF_FE04;
   localparam int          WORDS = 128;
   localparam int          TMO   = 16;
   localparam int          BOUND = 2000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        interrupt;
   logic [25:0] blk_addr_o;
   logic [31:0] blk_wdata_o, blk_rdata_i;
   logic        blk_rd_o, blk_we_o, blk_ack_i;

   blkdev_ctrl_if bus();

   blkdev_ctrl #(.TIMEOUT(TMO)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .interrupt   (interrupt),
      .blk_addr_o  (blk_addr_o),
      .blk_wdata_o (blk_wdata_o),
      .blk_rdata_i (blk_rdata_i),
      .blk_rd_o    (blk_rd_o),
      .blk_we_o    (blk_we_o),
      .blk_ack_i   (blk_ack_i)
   );

   always #5 clk = ~clk;

   int          passed = 0, total = 0, failed = 0;
   logic [31:0] ref_buf [WORDS];
   logic [31:0] ref_bar = 32'd0;
   int          mode = 0, n_ack = 0, miss = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: got %08h want %08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [1:0] s, input logic [1:0] off);
      logic [31:0] r;
      int          o;
      r = old;
      o = int'(off);
      if (s == 2'd0)      r[8*o +: 8] = d[7:0];
      else if (s == 2'd1) r[16*(o/2) +: 16] = d[15:0];
      else                r = d;
      return r;
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] s,
                                           input logic [1:0] off);
      int o;
      o = int'(off);
      if (s == 2'd0) return (w >> (8*o)) & 32'h0000_00FF;
      if (s == 2'd1) return (w >> (16*(o/2))) & 32'h0000_FFFF;
      return w;
   endfunction

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      int n;
      n = 0;
      @(negedge clk); #2;
      bus.addr_i = a; bus.data_i = d; bus.sel_i = s; bus.we_i = 1'b1;
      #1;
      while (!bus.ack_o && n < BOUND) begin @(negedge clk); #3; n++; end
      chk("wr_ack", 32'(bus.ack_o), 32'd1);
      @(posedge clk); #1;
      bus.we_i = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [1:0] s,
                           output logic [31:0] d, output int stall);
      int n;
      n = 0;
      @(negedge clk); #2;
      bus.addr_i = a; bus.sel_i = s; bus.rd_i = 1'b1;
      #1;
      while (!bus.ack_o && n < BOUND) begin @(negedge clk); #3; n++; end
      chk("rd_ack", 32'(bus.ack_o), 32'd1);
      d = bus.data_o;
      stall = n;
      @(posedge clk); #1;
      bus.rd_i = 1'b0;
   endtask

   // Counts strobe-high cycles; returns in the first strobe-low cycle
   task automatic wait_fin(output int hi);
      hi = 0;
      @(negedge clk); #2;
      while ((blk_rd_o || blk_we_o) && hi < BOUND) begin hi++; @(negedge clk); #2; end
      chk("strobes_low", {30'd0, blk_rd_o, blk_we_o}, 32'd0);
   endtask

   // Backend responder: mode 0 never acks, 1 acks every cycle with data=index, 2 acks randomly
   initial begin
      logic go;
      blk_ack_i = 1'b0;
      blk_rdata_i = 32'd0;
      forever begin
         @(negedge clk);
         blk_ack_i = 1'b0;
         if (blk_rd_o || blk_we_o) begin
            go = (mode == 1) || (mode == 2 && (miss >= 3 || $urandom_range(0, 2) != 0));
            if (go) begin
               blk_rdata_i = (mode == 1) ? 32'(n_ack) : $urandom;
               chk("blk_addr", 32'(blk_addr_o), ref_bar);
               if (blk_we_o) chk("blk_wdata", blk_wdata_o, ref_buf[n_ack % WORDS]);
               else          ref_buf[n_ack % WORDS] = blk_rdata_i;
               n_ack++;
               miss = 0;
               blk_ack_i = 1'b1;
            end else begin
               miss++;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, a;
      logic [1:0]  s, off;
      int          st, hi, i;

      bus.addr_i = 32'd0; bus.data_i = 32'd0; bus.sel_i = 2'd2;
      bus.rd_i = 1'b0; bus.we_i = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_irq", 32'(interrupt), 32'd0);
      chk("rst_strobes", {30'd0, blk_rd_o, blk_we_o}, 32'd0);
      chk("rst_ack", 32'(bus.ack_o), 32'd0);
      rst = 1'b0;
      bus_read(CSR_A, 2'd2, d, st); chk("rst_csr", d, 32'd0);
      bus_read(BAR_A, 2'd2, d, st); chk("rst_bar", d, 32'd0);

      // Byte/half merge into word 0
      bus_write(32'h0, 32'h0, 2'd2);
      bus_write(32'h1, 32'h0000_00AB, 2'd0);
      bus_write(32'h2, 32'h0000_1234, 2'd1);
      bus_read(32'h0, 2'd2, d, st); chk("merge_word", d, 32'h1234_AB00);
      bus_read(32'h1, 2'd0, d, st); chk("merge_byte", d, 32'h0000_00AB);
      bus_read(32'h2, 2'd1, d, st); chk("merge_half", d, 32'h0000_1234);

      // Fill the buffer, then random byte/half/word traffic against the model
      for (int k = 0; k < WORDS; k++) begin
         d = $urandom;
         ref_buf[k] = d;
         bus_write(32'(k * 4), d, 2'd2);
      end
      for (int k = 0; k < 60; k++) begin
         i   = $urandom_range(0, WORDS - 1);
         s   = 2'($urandom_range(0, 3));
         off = 2'($urandom_range(0, 3));
         a   = ($urandom & 32'h0000_FE00) | 32'(i * 4) | 32'(off);
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            ref_buf[i] = merge(ref_buf[i], d, s, off);
            bus_write(a, d, s);
         end else begin
            bus_read(a, s, d, st);
            chk("rand_rd", d, extract(ref_buf[i], s, off));
         end
      end

      // Full read block: BAR=5, START_RD|IE, ack every cycle with data=index
      ref_bar = 32'd5;
      bus_write(BAR_A, 32'd5, 2'd2);
      bus_read(BAR_A, 2'd2, d, st); chk("bar_rb", d, 32'd5);
      mode = 1; n_ack = 0;
      bus_write(CSR_A, 32'h4800_0000, 2'd2);
      wait_fin(hi);
      chk("rd_cycles", 32'(hi), 32'd128);
      chk("rd_acks", 32'(n_ack), 32'd128);
      chk("irq_in_fin", 32'(interrupt), 32'd0);
      @(negedge clk); #2;
      chk("irq_after_fin", 32'(interrupt), 32'd1);
      bus_read(CSR_A, 2'd2, d, st); chk("rd_csr", d, 32'h8800_0000);
      for (int k = 0; k < WORDS; k++) begin
         bus_read(32'(k * 4), 2'd2, d, st);
         chk("rd_buf", d, 32'(k));
      end

      // W1C of DONE landing on the FIN cycle loses to the hardware set
      n_ack = 0;
      bus_write(CSR_A, 32'h4000_0000, 2'd2);
      wait_fin(hi);
      bus.addr_i = CSR_A; bus.data_i = 32'h8000_0000; bus.sel_i = 2'd2; bus.we_i = 1'b1;
      #1;
      chk("fin_w1c_ack", 32'(bus.ack_o), 32'd1);
      @(posedge clk); #1;
      bus.we_i = 1'b0;
      bus_read(CSR_A, 2'd2, d, st); chk("fin_w1c_done", d, 32'h8000_0000);
      bus_write(CSR_A, 32'h8000_0000, 2'd2);
      bus_read(CSR_A, 2'd2, d, st); chk("idle_w1c", d, 32'd0);

      // Write block with random backend acks; BAR write ignored and buffer read stalled while busy
      for (int k = 0; k < WORDS; k++) begin
         d = $urandom;
         ref_buf[k] = d;
         bus_write(32'(k * 4), d, 2'd2);
      end
      mode = 2; n_ack = 0; miss = 0;
      bus_write(CSR_A, 32'h2000_0000, 2'd2);
      bus_read(CSR_A, 2'd2, d, st); chk("busy_csr", d, 32'h0400_0000);
      bus_write(BAR_A, 32'd7, 2'd2);
      bus_read(BAR_A, 2'd2, d, st); chk("bar_busy", d, 32'd5);
      bus_read(32'hC, 2'd2, d, st);
      chk("stall_acks_done", 32'(n_ack), 32'd128);
      chk("stall_len", 32'(st >= 128), 32'd1);
      chk("stall_data", d, ref_buf[3]);

      // Timeout with a silent backend
      mode = 0; n_ack = 0;
      bus_write(CSR_A, 32'h4000_0000, 2'd2);
      wait_fin(hi);
      chk("tmo_cycles", 32'(hi), 32'(TMO));
      @(negedge clk); #2;
      chk("tmo_strobes", {30'd0, blk_rd_o, blk_we_o}, 32'd0);
      bus_read(CSR_A, 2'd2, d, st); chk("tmo_csr", d, 32'h9000_0000);
      bus_write(CSR_A, 32'h9000_0000, 2'd2);

      // Abort a read around word 40
      mode = 1; n_ack = 0;
      bus_write(CSR_A, 32'h4000_0000, 2'd2);
      st = 0;
      @(negedge clk); #2;
      while (n_ack < 40 && st < BOUND) begin @(negedge clk); #2; st++; end
      chk("abort_reach", 32'(n_ack >= 40), 32'd1);
      bus.addr_i = CSR_A; bus.data_i = 32'h0200_0000; bus.sel_i = 2'd2; bus.we_i = 1'b1;
      @(posedge clk); #1;
      bus.we_i = 1'b0;
      @(negedge clk); #2;
      chk("abort_strobes", {30'd0, blk_rd_o, blk_we_o}, 32'd0);
      @(negedge clk); #2;
      bus_read(CSR_A, 2'd2, d, st); chk("abort_csr", d, 32'h9000_0000);
      chk("abort_partial", 32'(n_ack < 128), 32'd1);
      for (int k = 0; k < 64; k++) begin
         bus_read(32'(k * 4), 2'd2, d, st);
         chk("abort_buf", d, ref_buf[k]);
      end

      // Reset in the middle of a write block
      n_ack = 0;
      bus_write(CSR_A, 32'h2800_0000, 2'd2);
      repeat (10) @(negedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      ref_bar = 32'd0;
      chk("rst_mid_strobes", {30'd0, blk_rd_o, blk_we_o}, 32'd0);
      chk("rst_mid_irq", 32'(interrupt), 32'd0);
      chk("rst_mid_addr", 32'(blk_addr_o), 32'd0);
      chk("rst_mid_wdata", blk_wdata_o, 32'd0);
      chk("rst_mid_ack", 32'(bus.ack_o), 32'd0);
      chk("rst_mid_data", bus.data_o, 32'd0);
      bus_read(CSR_A, 2'd2, d, st); chk("rst_mid_csr", d, 32'd0);
      bus_read(BAR_A, 2'd2, d, st); chk("rst_mid_bar", d, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/blkdev_ctrl.md
BLKDEV_CTRL -- requirements
Module: blkdev_ctrl

Interface
REQ-001 SHALL have parameter CTRL_ADDR, default 32'hFFFF_FE00, which is the control/status register (CSR) address; the block-address register (BAR) sits at CTRL_ADDR+4.
REQ-002 SHALL have parameter WORDS, default 128, which is the number of 32-bit buffer words per block; it is a power of two, 4..1024.
REQ-003 SHALL have parameter BADDR_W, default 26, which is the backend block-address width.
REQ-004 SHALL have parameter TIMEOUT, default 65535, which is the maximum number of cycles to wait for blk_ack_i per word.
REQ-005 SHALL have port clk, input, 1 bit: the clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have ports addr_i, data_i (input, 32 bits), data_o (output, 32 bits) and sel_i (input, 2 bits: 0 byte, 1 half, 2/3 word): the bus.
REQ-008 SHALL have ports rd_i and we_i (input, 1 bit) and ack_o (output, 1 bit): the bus strobes and acknowledge.
REQ-009 SHALL have port interrupt, output, 1 bit: CSR.DONE & CSR.IE.
REQ-010 SHALL have ports blk_addr_o (output, BADDR_W), blk_wdata_o (output, 32 bits) and blk_rdata_i (input, 32 bits): the backend.
REQ-011 SHALL have ports blk_rd_o, blk_we_o (output, 1 bit) and blk_ack_i (input, 1 bit): the backend handshake, one word per ack.

Function
REQ-012 SHALL define CSR bits as: [31] DONE (W1C), [30] START_RD, [29] START_WR, [28] ERR (W1C), [27] IE, [26] BUSY (RO), [25] ABORT (write-only, reads 0); other bits read 0.
REQ-013 SHALL decode buffer accesses as any address other than CSR/BAR, indexed by addr_i[log2(WORDS)+1:2].
REQ-014 SHALL acknowledge CSR/BAR accesses combinationally (ack_o=1) in the same cycle.
REQ-015 SHALL acknowledge buffer accesses the same cycle when idle, and hold ack_o=0 (stall) while BUSY.
REQ-016 SHALL merge buffer writes per byte lane in one cycle: sel 0 writes byte addr_i[1:0]; sel 1 writes half addr_i[1]; otherwise the full word.
REQ-017 SHALL zero-extend buffer reads from the addressed byte/half; CSR reads return the CSR and BAR reads return the zero-extended BAR.
REQ-018 SHALL use FSM states IDLE, RD, WR, FIN.
REQ-019 SHALL go IDLE->RD on a CSR write with START_RD=1, or IDLE->WR on START_WR=1; both set means RD; in either case word counter=0, BUSY=1, DONE=0 and ERR=0.
REQ-020 SHALL ignore START bits while BUSY.
REQ-021 In RD/WR, SHALL hold blk_rd_o/blk_we_o high and blk_addr_o=BAR, with blk_wdata_o=buffer[counter].
REQ-022 In RD, SHALL store blk_rdata_i to buffer[counter] on each blk_ack_i.
REQ-023 SHALL increment counter on each blk_ack_i, and go to FIN on the ack at counter==WORDS-1.
REQ-024 SHALL reset the per-word timeout counter on each ack; reaching TIMEOUT sets ERR and goes to FIN.
REQ-025 SHALL treat a CSR write with ABORT=1 while BUSY as: drop blk strobes next cycle, set ERR, go to FIN; the buffer holds partial data.
REQ-026 FIN SHALL last one cycle: DONE=1, BUSY=0, then go to IDLE.
REQ-027 SHALL deassert blk_rd_o/blk_we_o in FIN and IDLE.
REQ-028 On a simultaneous FIN DONE-set and software W1C of DONE, set wins.
REQ-029 SHALL ignore BAR writes while BUSY; BAR reads remain valid.
REQ-030 SHALL ignore blk_ack_i outside RD/WR.

Reset
REQ-031 On rst, SHALL set CSR=0, BAR=0, state=IDLE, counter=0, timeout=0, blk_rd_o=0, blk_we_o=0 and interrupt=0; reset mid-transfer aborts silently with DONE=0.
REQ-032 Reset SHALL leave buffer contents undefined.

Structure
REQ-033 SHALL place in package blkdev_pkg: the state enum and the CSR bit-position constants (DONE, START_RD, START_WR, ERR, IE, BUSY, ABORT).
REQ-034 SHALL instantiate a single sub-module blkdev_buffer: WORDS x 32, asynchronous read, synchronous write, one port muxed between bus (IDLE) and FSM counter (RD/WR).

Verification
REQ-035 SHALL verify: BAR=5, CSR=0x4800_0000, backend acks every cycle with data=index -> 128 acks, buffer[i]=i, DONE=1, interrupt=1 one cycle after FIN.
REQ-036 SHALL verify: byte write 0xAB to addr 0x001, then half 0x1234 to 0x002 over word 0 -> read word 0 = 0x1234AB00.
REQ-037 SHALL verify: WR start, bus read of buffer word 3 during BUSY -> ack_o=0 until FIN, then data returned.
REQ-038 SHALL verify: TIMEOUT=16, backend never acks -> ERR=1, DONE=1 on cycle 17, strobes low.
REQ-039 SHALL verify: ABORT at word 40 of RD -> ERR=1, DONE=1, strobes low next cycle; then rst mid-WR -> all outputs 0.
REQ-040 SHALL verify: CSR write 0x8000_0000 (W1C) on the FIN cycle -> DONE stays 1.
